// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and pipeline-register strobe bundle
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  // Hazard sources observed in ID, EX and MEM
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  // Per-stage enables and flushes
  logic                  pc_enable;
  logic                  ifid_enable;
  logic                  ifid_flush;
  logic                  idex_enable;
  logic                  idex_flush;
  logic                  exmem_enable;
  logic                  memwb_enable;

  // Pipeline datapath side: reports hazards, consumes strobes
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, mem_req, mem_ready,
    input  pc_enable, ifid_enable, ifid_flush, idex_enable,
           idex_flush, exmem_enable, memwb_enable
  );

  // Hazard controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, mem_req, mem_ready,
    output pc_enable, ifid_enable, ifid_flush, idex_enable,
           idex_flush, exmem_enable, memwb_enable
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard sequencer; HAZARD_STATS_EN adds event counters
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_MAX = 15
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W       = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   hz,
  output logic                    mem_timeout,
  output logic [1:0]              state
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_lu,
  output logic [STAT_W-1:0]       stat_flush,
  output logic [STAT_W-1:0]       stat_wait
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic [REG_ADDR_W-1:0] id_rs_w, id_rt_w, ex_rt_w;
  logic lu;
  logic mem_stall;

  logic pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en;
  logic eval_normal;
  logic lu_allowed;
  logic evt_lu, evt_flush, evt_wait;

  assign id_rs_w = hz.id_rs;
  assign id_rt_w = hz.id_rt;
  assign ex_rt_w = hz.ex_rt;

  // Load in EX writes a register the ID instruction is about to read
  assign lu = hz.ex_mem_read && (ex_rt_w != '0) &&
              ((ex_rt_w == id_rs_w) || (hz.id_uses_rt && (ex_rt_w == id_rt_w)));

  assign mem_stall = hz.mem_req && !hz.mem_ready;

  // Strobes and next state from current state and live hazard inputs
  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_fl       = 1'b0;
    idex_en       = 1'b0;
    idex_fl       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    eval_normal   = 1'b0;
    lu_allowed    = 1'b0;
    evt_lu        = 1'b0;
    evt_flush     = 1'b0;
    evt_wait      = 1'b0;

    if (!reset) begin
      ifid_fl       = 1'b1;
      idex_fl       = 1'b1;
      state_d       = S_RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_stall) begin
            state_d    = S_MEM_WAIT;
            wait_cnt_d = 8'd1;
          end else begin
            eval_normal = 1'b1;
            lu_allowed  = 1'b1;
          end
        end
        S_FLUSH: begin
          // ID holds the NOP injected by the flush, so no load-use check
          if (mem_stall) begin
            state_d    = S_MEM_WAIT;
            wait_cnt_d = 8'd1;
          end else begin
            eval_normal = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (!hz.mem_ready) begin
            evt_wait = 1'b1;
            if (wait_cnt_q < WAIT_MAX) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
              mem_timeout_d = 1'b1;
              state_d       = S_HALT;
            end
          end else begin
            wait_cnt_d  = '0;
            eval_normal = 1'b1;
            lu_allowed  = 1'b1;
          end
        end
        default: begin
          // Frozen until reset; timeout flag is left as is
        end
      endcase

      // Branch beats load-use: the flush already discards the ID instruction
      if (eval_normal) begin
        if (hz.branch_taken) begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          ifid_fl   = 1'b1;
          idex_en   = 1'b1;
          idex_fl   = 1'b1;
          exmem_en  = 1'b1;
          memwb_en  = 1'b1;
          state_d   = S_FLUSH;
          evt_flush = 1'b1;
        end else if (lu_allowed && lu) begin
          idex_en  = 1'b1;
          idex_fl  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          state_d  = S_RUN;
          evt_lu   = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          state_d  = S_RUN;
        end
      end
    end
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  assign hz.pc_enable    = pc_en;
  assign hz.ifid_enable  = ifid_en;
  assign hz.ifid_flush   = ifid_fl;
  assign hz.idex_enable  = idex_en;
  assign hz.idex_flush   = idex_fl;
  assign hz.exmem_enable = exmem_en;
  assign hz.memwb_enable = memwb_en;
  assign mem_timeout     = mem_timeout_q;
  assign state           = state_q;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_lu_q, stat_lu_d;
  logic [STAT_W-1:0] stat_flush_q, stat_flush_d;
  logic [STAT_W-1:0] stat_wait_q, stat_wait_d;

  // Saturating event counters
  always_comb begin
    stat_lu_d    = stat_lu_q;
    stat_flush_d = stat_flush_q;
    stat_wait_d  = stat_wait_q;
    if (!reset) begin
      stat_lu_d    = '0;
      stat_flush_d = '0;
      stat_wait_d  = '0;
    end else begin
      if (evt_lu && (stat_lu_q != '1))
        stat_lu_d = stat_lu_q + 1'b1;
      if (evt_flush && (stat_flush_q != '1))
        stat_flush_d = stat_flush_q + 1'b1;
      if (evt_wait && (stat_wait_q != '1))
        stat_wait_d = stat_wait_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    stat_lu_q    <= stat_lu_d;
    stat_flush_q <= stat_flush_d;
    stat_wait_q  <= stat_wait_d;
  end

  assign stat_lu    = stat_lu_q;
  assign stat_flush = stat_flush_q;
  assign stat_wait  = stat_wait_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [15:0] stat_lu, stat_flush, stat_wait;
`endif

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hif ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .MEM_WAIT_MAX(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hz         (hif.slave),
    .mem_timeout(mem_timeout),
    .state      (state)
`ifdef HAZARD_STATS_EN
    ,
    .stat_lu    (stat_lu),
    .stat_flush (stat_flush),
    .stat_wait  (stat_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe order: {pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [6:0] ALL = 7'b1101011;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] BR  = 7'b1111111;
  localparam logic [6:0] LU  = 7'b0001111;
  localparam logic [6:0] RST = 7'b0010100;

  typedef struct {
    logic [6:0] strb;
    logic [1:0] st;
    logic       to;
    logic       chk_stats;
    int         s_lu;
    int         s_fl;
    int         s_wt;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   pushed  = 0;
  int   popped  = 0;
  bit   done    = 1'b0;

  bit   chk_stats_nx = 1'b0;
  int   x_lu = 0, x_fl = 0, x_wt = 0;

  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] ert,
                      input logic br, input logic mq, input logic rdy,
                      input logic [6:0] strb, input logic [1:0] st, input logic to,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rst;
    hif.id_rs        = rs;
    hif.id_rt        = rt;
    hif.id_uses_rt   = urt;
    hif.ex_mem_read  = mr;
    hif.ex_rt        = ert;
    hif.branch_taken = br;
    hif.mem_req      = mq;
    hif.mem_ready    = rdy;
    e.strb      = strb;
    e.st        = st;
    e.to        = to;
    e.chk_stats = chk_stats_nx;
    e.s_lu      = x_lu;
    e.s_fl      = x_fl;
    e.s_wt      = x_wt;
    e.name      = name;
    sb_q.push_back(e);
    pushed++;
  endtask

  task automatic idle(input logic [1:0] st, input string name);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ALL, st, 0, name);
  endtask

  // Stimulus
  initial begin
    reset            = 1'b0;
    hif.id_rs        = '0;
    hif.id_rt        = '0;
    hif.id_uses_rt   = 1'b0;
    hif.ex_mem_read  = 1'b0;
    hif.ex_rt        = '0;
    hif.branch_taken = 1'b0;
    hif.mem_req      = 1'b0;
    hif.mem_ready    = 1'b0;
    @(posedge clk);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, "reset");
    idle(0, "idle0");
    step(1, 8, 0, 0, 1, 8, 0, 0, 0, LU,  0, 0, "lu_rs");
    idle(0, "post_lu");
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, ALL, 0, 0, "lu_r0");
    step(1, 3, 9, 1, 1, 9, 0, 0, 0, LU,  0, 0, "lu_rt");
    step(1, 3, 9, 0, 1, 9, 0, 0, 0, ALL, 0, 0, "rt_unused");

    step(1, 0, 0, 0, 0, 0, 1, 0, 0, BR,  0, 0, "branch");
    step(1, 8, 0, 0, 1, 8, 0, 0, 0, ALL, 2, 0, "flush_lu_sup");
    idle(0, "post_flush");

    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, "stall1");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, "stall2");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, "stall3");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, ALL, 1, 0, "ready");
    idle(0, "post_ready");

    step(1, 8, 0, 0, 1, 8, 1, 1, 0, FRZ, 0, 0, "combo_stall");
    step(1, 8, 0, 0, 1, 8, 1, 1, 0, FRZ, 1, 0, "combo_wait");
    step(1, 8, 0, 0, 1, 8, 1, 1, 1, BR,  1, 0, "combo_rel");
    idle(2, "combo_flush");
    idle(0, "combo_run");

    step(1, 0, 0, 0, 0, 0, 1, 0, 0, BR,  0, 0, "br_a");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 2, 0, "flush_stall");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, ALL, 1, 0, "flush_stall_rel");
    idle(0, "flush_stall_run");

    step(1, 0, 0, 0, 0, 0, 1, 0, 0, BR,  0, 0, "br_b");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, BR,  2, 0, "br_in_flush");
    idle(2, "br_in_flush_end");
    idle(0, "br_in_flush_run");

    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, "to_enter");
    for (int i = 0; i < 15; i++)
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, "to_wait");
    chk_stats_nx = 1'b1;
    x_lu = 2; x_fl = 5; x_wt = 18;
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 3, 1, "halt");
    chk_stats_nx = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 3, 1, "halt_hold");

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 3, 1, "rst_halt");
    chk_stats_nx = 1'b1;
    x_lu = 0; x_fl = 0; x_wt = 0;
    idle(0, "after_rst");
    chk_stats_nx = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, "w_enter");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, "w_wait");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, RST, 1, 0, "rst_wait");
    idle(0, "after_rst_wait");

    done = 1'b1;
  end

  // Monitor: pops one expectation per cycle, sampled mid-cycle
  initial begin : monitor
    exp_t       e;
    logic [6:0] act;
    int         cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        popped++;
        act = {hif.pc_enable, hif.ifid_enable, hif.ifid_flush, hif.idex_enable,
               hif.idex_flush, hif.exmem_enable, hif.memwb_enable};
        checks++;
        if (act !== e.strb) begin
          errors++;
          $display("FAIL %s strobes: got %b want %b", e.name, act, e.strb);
        end
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
        end
        checks++;
        if (mem_timeout !== e.to) begin
          errors++;
          $display("FAIL %s mem_timeout: got %b want %b", e.name, mem_timeout, e.to);
        end
`ifdef HAZARD_STATS_EN
        if (e.chk_stats) begin
          checks++;
          if (int'(stat_lu) != e.s_lu) begin
            errors++;
            $display("FAIL %s stat_lu: got %0d want %0d", e.name, stat_lu, e.s_lu);
          end
          checks++;
          if (int'(stat_flush) != e.s_fl) begin
            errors++;
            $display("FAIL %s stat_flush: got %0d want %0d", e.name, stat_flush, e.s_fl);
          end
          checks++;
          if (int'(stat_wait) != e.s_wt) begin
            errors++;
            $display("FAIL %s stat_wait: got %0d want %0d", e.name, stat_wait, e.s_wt);
          end
        end
`endif
      end else if (done) begin
        break;
      end
      if (cyc > 5000) begin
        errors++;
        $display("FAIL watchdog: got %0d cycles want at most 5000", cyc);
        break;
      end
    end
    checks++;
    if (popped != pushed || pushed == 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d popped want %0d", popped, pushed);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
